// File: rtl/prog_mem_arbiter.sv
// prog_mem_arbiter: round-robin fetch/loader arbiter for the 0x31B0-0x35AF program-memory window
module prog_mem_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_31B0,
    parameter logic [31:0] LAST_ADDR = 32'h0000_35AF,
    parameter int          MEM_AW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [31:0]       fetch_rdata,
    output logic              fetch_err,
    input  logic              load_req,
    input  logic [31:0]       load_addr,
    input  logic [31:0]       load_wdata,
    output logic              load_gnt,
    output logic              load_err,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [7:0]        fault_count
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [31:0] SPAN = LAST_ADDR - BASE_ADDR;
    state_t      state;
    logic        sel_load, last_load, ok, acc, pick_load;
    logic [31:0] addr_q, wdata_q, off;
    // An address below BASE wraps to a huge offset, so one unsigned compare covers both bounds
    assign off       = addr_q - BASE_ADDR;
    assign ok        = (off <= SPAN) && (off[1:0] == 2'b00);
    assign acc       = state == ACCESS;
    assign pick_load = load_req && (!fetch_req || !last_load);
    assign fetch_gnt   = acc && !sel_load;
    assign load_gnt    = acc && sel_load;
    assign fetch_err   = fetch_gnt && !ok;
    assign load_err    = load_gnt && !ok;
    assign mem_cs      = acc && ok;
    assign mem_we      = mem_cs && sel_load;
    assign mem_addr    = mem_cs ? off[MEM_AW+1:2] : '0;
    assign mem_wdata   = mem_we ? wdata_q : '0;
    assign fetch_valid = state == RESP;
    assign fetch_rdata = fetch_valid ? mem_rdata : '0;
    // Sequencer: capture the winner in IDLE, perform one access cycle, then a read-response cycle for fetches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel_load    <= 1'b0;
            last_load   <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            fault_count <= '0;
        end else begin
            case (state)
                IDLE: if (fetch_req || load_req) begin
                    sel_load <= pick_load;
                    addr_q   <= pick_load ? load_addr : fetch_addr;
                    wdata_q  <= load_wdata;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    last_load <= sel_load;
                    if (!ok && fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
                    state <= (ok && !sel_load) ? RESP : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_mem_arbiter.sv
// tb_prog_mem_arbiter: directed checks of arbitration, decode, timing, reset and fault saturation
module tb_prog_mem_arbiter;
    localparam logic [31:0] BASE = 32'h0000_31B0;
    logic        clk = 1'b0, rst = 1'b1, init = 1'b0;
    logic        fetch_req = 1'b0, load_req = 1'b0;
    logic [31:0] fetch_addr = '0, load_addr = '0, load_wdata = '0;
    logic        fetch_gnt, fetch_valid, fetch_err, load_gnt, load_err, mem_cs, mem_we;
    logic [31:0] fetch_rdata, mem_wdata, mem_rdata = '0;
    logic [7:0]  mem_addr, fault_count;
    logic [31:0] mem [256];
    int          n_checks = 0, n_fail = 0;

    prog_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
        .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
        .load_gnt(load_gnt), .load_err(load_err),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: read data appears the cycle after the read select
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 256; i++) mem[i] <= i;
        end else begin
            if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_cs && !mem_we) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic err, input logic [31:0] ma, input logic [31:0] d);
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_addr = a;
        @(negedge clk);
        fetch_req = 1'b0;
        check("f_gnt", 32'(fetch_gnt), 32'd1);
        check("f_err", 32'(fetch_err), 32'(err));
        check("f_cs", 32'(mem_cs), 32'(!err));
        check("f_we", 32'(mem_we), 32'd0);
        check("f_valid_early", 32'(fetch_valid), 32'd0);
        if (!err) begin
            check("f_maddr", 32'(mem_addr), ma);
            @(negedge clk);
            check("f_valid", 32'(fetch_valid), 32'd1);
            check("f_rdata", fetch_rdata, d);
            check("f_gnt_resp", 32'(fetch_gnt), 32'd0);
            check("f_err_resp", 32'(fetch_err), 32'd0);
        end
    endtask

    initial begin
        int pulses, n;
        #3;
        check("rst_gnt", 32'({fetch_gnt, load_gnt, fetch_err, load_err}), 32'd0);
        check("rst_mem", 32'({mem_cs, mem_we, fetch_valid}), 32'd0);
        check("rst_fc", 32'(fault_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_fetch(32'h31AC, 1'b1, 32'd0, 32'd0);
        @(negedge clk);
        check("fc_one", 32'(fault_count), 32'd1);
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_addr = 32'h31B0;
        @(posedge clk);
        #2;
        check("rst_pre_gnt", 32'(fetch_gnt), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_gnt", 32'({fetch_gnt, fetch_err, load_gnt, load_err}), 32'd0);
        check("rst_async_mem", 32'({mem_cs, mem_we, fetch_valid}), 32'd0);
        check("rst_async_maddr", 32'(mem_addr), 32'd0);
        check("rst_async_rdata", fetch_rdata, 32'd0);
        check("rst_async_fc", 32'(fault_count), 32'd0);
        fetch_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_valid", 32'({fetch_valid, fetch_gnt, fetch_err}), 32'd0);
        end
        @(negedge clk);
        fetch_req = 1'b1;
        fetch_addr = 32'h31B0;
        load_req = 1'b1;
        load_addr = 32'h31B4;
        load_wdata = 32'h55;
        for (int g = 0; g < 6; g++) begin
            n = 0;
            while (!(fetch_gnt || load_gnt) && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("cont_timeout", 32'(n < 10), 32'd1);
            check("cont_order", 32'({fetch_gnt, load_gnt}), (g % 2 == 0) ? 32'd2 : 32'd1);
            if (g == 5) begin
                fetch_req = 1'b0;
                load_req = 1'b0;
            end
            @(negedge clk);
        end
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        for (int i = 0; i < 256; i++) do_fetch(BASE + 32'(i * 4), 1'b0, 32'(i), 32'(i));
        @(negedge clk);
        check("fc_zero", 32'(fault_count), 32'd0);
        do_fetch(32'h31AC, 1'b1, 32'd0, 32'd0);
        do_fetch(32'h35B0, 1'b1, 32'd0, 32'd0);
        do_fetch(32'h31B2, 1'b1, 32'd0, 32'd0);
        @(negedge clk);
        check("fc_three", 32'(fault_count), 32'd3);
        load_req = 1'b1;
        load_addr = 32'h35AC;
        load_wdata = 32'hDEADBEEF;
        @(negedge clk);
        load_req = 1'b0;
        check("l_gnt", 32'(load_gnt), 32'd1);
        check("l_cs_we", 32'({mem_cs, mem_we}), 32'd3);
        check("l_maddr", 32'(mem_addr), 32'hFF);
        check("l_wdata", mem_wdata, 32'hDEADBEEF);
        check("l_err", 32'(load_err), 32'd0);
        do_fetch(32'h35AC, 1'b0, 32'hFF, 32'hDEADBEEF);
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            load_req = 1'b1;
            load_addr = 32'h0;
            @(negedge clk);
            load_req = 1'b0;
            if (load_err && !mem_cs) pulses++;
        end
        check("sat_pulses", 32'(pulses), 32'd300);
        @(negedge clk);
        check("sat_fc", 32'(fault_count), 32'd255);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
